// File: rtl/otter_intrpt_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : otter_defines
//  Brief    : Shared definitions for the OTTER interrupt controller: source
//             count default, controller state enum and cause-width helper.
//  Revision : 1.0  initial release
// ============================================================================
package otter_defines;

    // Default number of external interrupt sources (legal range 2..8).
    localparam int c_NUM_SRC_DEFAULT = 4;

    // Controller states, shared so every user agrees on the encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_TAKE  = 2'd2,
        ST_RET   = 2'd3
    } intrpt_state_e;

    // Width of the trap cause index for a given source count.
    function automatic int cause_w(input int num_src);
        return (num_src <= 2) ? 1 : $clog2(num_src);
    endfunction

endpackage : otter_defines
`default_nettype wire

// File: rtl/otter_intrpt_pend.sv
`default_nettype none
// ============================================================================
//  Module   : otter_intrpt_pend
//  Brief    : One interrupt source: input sampling, rising-edge detect and
//             pending latch. With OTTER_INTRPT_SYNC_EN defined the input goes
//             through a 2-flop synchronizer (edge-to-pending 3 cycles);
//             otherwise it is registered once (edge-to-pending 2 cycles).
//  Revision : 1.0  initial release
// ============================================================================
module otter_intrpt_pend (
    input  logic clk,
    input  logic rst_n,
    input  logic irq,
    input  logic ack,
    output logic pending
);

`ifdef OTTER_INTRPT_SYNC_EN
    localparam int c_STAGES = 2;
`else
    localparam int c_STAGES = 1;
`endif

    logic [c_STAGES-1:0] r_smp;
    logic [c_STAGES-1:0] r_smp_vld;
    logic                r_prev;
    logic                r_prev_vld;
    logic                r_pending;
    logic                w_rise;

    // Sample chain; valid bits mark flops holding a real post-reset sample so a
    // level already high when reset releases is never mistaken for an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_smp      <= '0;
            r_smp_vld  <= '0;
            r_prev     <= 1'b0;
            r_prev_vld <= 1'b0;
        end else begin
`ifdef OTTER_INTRPT_SYNC_EN
            r_smp      <= {r_smp[0], irq};
            r_smp_vld  <= {r_smp_vld[0], 1'b1};
`else
            r_smp      <= irq;
            r_smp_vld  <= 1'b1;
`endif
            r_prev     <= r_smp[c_STAGES-1];
            r_prev_vld <= r_smp_vld[c_STAGES-1];
        end
    end

    // A rise needs an observed low before an observed high.
    assign w_rise = r_smp[c_STAGES-1] & r_smp_vld[c_STAGES-1] & ~r_prev & r_prev_vld;

    // Pending latch: ack clears, but a rise in the same cycle wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~ack) | w_rise;
        end
    end

    assign pending = r_pending;

endmodule : otter_intrpt_pend
`default_nettype wire

// File: rtl/otter_intrpt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : otter_intrpt_ctrl
//  Brief    : Interrupt controller for the OTTER core. Latches source edges,
//             arms when interrupts are enabled, and at the next instruction
//             boundary takes the lowest-index pending source (redirect to
//             mtvec) or, for a retiring mret, redirects to mepc.
//             Build option: OTTER_INTRPT_SYNC_EN (2-flop irq synchronizers).
//  Revision : 1.0  initial release
// ============================================================================
module otter_intrpt_ctrl
    import otter_defines::*;
#(
    parameter int NUM_SRC = c_NUM_SRC_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_SRC-1:0]          irq,
    input  logic                        csr_mie,
    input  logic                        instr_retire,
    input  logic                        mret,
    input  logic [31:0]                 csr_mtvec,
    input  logic [31:0]                 csr_mepc,
    output logic                        intrpt_taken,
    output logic [cause_w(NUM_SRC)-1:0] trap_cause,
    output logic [NUM_SRC-1:0]          irq_ack,
    output logic                        pc_redirect,
    output logic [31:0]                 pc_target,
    output logic                        flush
);

    localparam int c_CW = cause_w(NUM_SRC);

    intrpt_state_e       r_state;
    logic [c_CW-1:0]     r_cause;
    logic [NUM_SRC-1:0]  w_pending;
    logic [NUM_SRC-1:0]  w_win_oh;
    logic [c_CW-1:0]     w_win_idx;
    logic                w_take;
    logic                w_ret;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_pend
        otter_intrpt_pend u_pend (
            .clk     (clk),
            .rst_n   (rst_n),
            .irq     (irq[g]),
            .ack     (irq_ack[g]),
            .pending (w_pending[g])
        );
    end

    // Fixed-priority winner, lowest index highest; scanned high to low so the
    // last match (the lowest set bit) sticks.
    always_comb begin
        w_win_idx = '0;
        w_win_oh  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_pending[i]) begin
                w_win_idx   = c_CW'(i);
                w_win_oh    = '0;
                w_win_oh[i] = 1'b1;
            end
        end
    end

    // Controller state machine; an interrupt beats an mret retiring in ARMED.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (instr_retire && mret)
                        r_state <= ST_RET;
                    else if ((|w_pending) && csr_mie)
                        r_state <= ST_ARMED;
                end
                ST_ARMED: begin
                    if (!csr_mie)
                        r_state <= ST_IDLE;
                    else if (instr_retire)
                        r_state <= ST_TAKE;
                end
                ST_TAKE: r_state <= ST_IDLE;
                ST_RET:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Hold the cause of the most recent take for readers outside TAKE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cause <= '0;
        end else if (r_state == ST_TAKE) begin
            r_cause <= w_win_idx;
        end
    end

    // Outputs decode the state register; the winner is taken from the pending
    // bits live in TAKE so a higher-priority edge arriving while ARMED wins.
    assign w_take       = (r_state == ST_TAKE);
    assign w_ret        = (r_state == ST_RET);
    assign intrpt_taken = w_take;
    assign flush        = w_take | w_ret;
    assign pc_redirect  = w_take | w_ret;
    assign irq_ack      = w_take ? w_win_oh : '0;
    assign trap_cause   = w_take ? w_win_idx : r_cause;
    assign pc_target    = w_take ? csr_mtvec : (w_ret ? csr_mepc : 32'h0);

endmodule : otter_intrpt_ctrl
`default_nettype wire

// File: tb/tb_otter_intrpt_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_otter_intrpt_ctrl
//  Brief    : Scoreboard bench for otter_intrpt_ctrl: directed scenarios then
//             randomized stimulus, predicted by an event-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_otter_intrpt_ctrl;

    localparam int NUM_SRC = otter_defines::c_NUM_SRC_DEFAULT;
    localparam int CW      = otter_defines::cause_w(NUM_SRC);
`ifdef OTTER_INTRPT_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NUM_SRC-1:0] irq;
    logic               csr_mie;
    logic               instr_retire;
    logic               mret;
    logic [31:0]        csr_mtvec;
    logic [31:0]        csr_mepc;
    logic               intrpt_taken;
    logic [CW-1:0]      trap_cause;
    logic [NUM_SRC-1:0] irq_ack;
    logic               pc_redirect;
    logic [31:0]        pc_target;
    logic               flush;

    otter_intrpt_ctrl #(.NUM_SRC(NUM_SRC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq          (irq),
        .csr_mie      (csr_mie),
        .instr_retire (instr_retire),
        .mret         (mret),
        .csr_mtvec    (csr_mtvec),
        .csr_mepc     (csr_mepc),
        .intrpt_taken (intrpt_taken),
        .trap_cause   (trap_cause),
        .irq_ack      (irq_ack),
        .pc_redirect  (pc_redirect),
        .pc_target    (pc_target),
        .flush        (flush)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic               taken;
        logic [CW-1:0]      cause;
        logic [NUM_SRC-1:0] ack;
        logic [31:0]        target;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // ---------------- reference model (event level) ----------------
    logic [NUM_SRC-1:0] hist[$];     // irq samples since reset, oldest first
    logic [NUM_SRC-1:0] m_pend;
    logic [NUM_SRC-1:0] m_rise;
    logic [NUM_SRC-1:0] m_nxt;
    bit                 m_armed;
    bit                 m_in_ret;
    int                 m_take_win;  // source being taken this cycle, -1 if none
    int                 m_last_cause;

    function automatic int lowest(input logic [NUM_SRC-1:0] v);
        for (int i = 0; i < NUM_SRC; i++) if (v[i]) return i;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            hist.delete();
            m_pend       = '0;
            m_armed      = 0;
            m_in_ret     = 0;
            m_take_win   = -1;
            m_last_cause = 0;
        end else begin
            hist.push_back(irq);
            m_rise = '0;
            // a source goes pending LAT edges after its first high sample, if
            // the sample before it was a post-reset low
            if (hist.size() >= LAT + 1)
                m_rise = hist[hist.size()-LAT] & ~hist[hist.size()-LAT-1];
            if (hist.size() > 16) void'(hist.pop_front());
            m_nxt = m_pend;
            if (m_take_win >= 0) begin
                m_nxt[m_take_win] = 1'b0;
                m_last_cause      = m_take_win;
            end
            m_nxt = m_nxt | m_rise;
            if (m_take_win >= 0 || m_in_ret) begin
                m_take_win = -1;
                m_in_ret   = 0;
            end else if (m_armed) begin
                if (!csr_mie) begin
                    m_armed = 0;
                end else if (instr_retire) begin
                    m_armed    = 0;
                    m_take_win = lowest(m_nxt);
                    exp_q.push_back('{taken: 1'b1, cause: CW'(m_take_win),
                                      ack: NUM_SRC'(1) << m_take_win, target: csr_mtvec});
                end
            end else begin
                if (instr_retire && mret) begin
                    m_in_ret = 1;
                    exp_q.push_back('{taken: 1'b0, cause: CW'(m_last_cause),
                                      ack: '0, target: csr_mepc});
                end else if (csr_mie && (|m_pend)) begin
                    m_armed = 1;
                end
            end
            m_pend = m_nxt;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (pc_redirect || flush || intrpt_taken || (irq_ack != '0)) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: taken=%b redir=%b flush=%b ack=%b target=%h, expected no activity",
                             intrpt_taken, pc_redirect, flush, irq_ack, pc_target);
                end else begin
                    e = exp_q.pop_front();
                    if ({intrpt_taken, pc_redirect, flush, trap_cause, irq_ack, pc_target} !==
                        {e.taken, 1'b1, 1'b1, e.cause, e.ack, e.target}) begin
                        n_fail++;
                        $display("FAIL event: got taken=%b redir=%b flush=%b cause=%0d ack=%b target=%h, expected taken=%b redir=1 flush=1 cause=%0d ack=%b target=%h",
                                 intrpt_taken, pc_redirect, flush, trap_cause, irq_ack, pc_target,
                                 e.taken, e.cause, e.ack, e.target);
                    end
                end
            end else if (exp_q.size() != 0) begin
                n_tests++;
                n_fail++;
                e = exp_q.pop_front();
                $display("FAIL missing_event: got no redirect, expected taken=%b cause=%0d target=%h",
                         e.taken, e.cause, e.target);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic retire_pulse(input logic is_mret);
        instr_retire = 1'b1;
        mret         = is_mret;
        tick();
        instr_retire = 1'b0;
        mret         = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; irq = '0; csr_mie = 1'b0; instr_retire = 1'b0; mret = 1'b0;
        csr_mtvec = 32'h8000_0040; csr_mepc = 32'h0000_0120;
        tick(3);
        check("rst_taken",  32'(intrpt_taken), 32'd0);
        check("rst_redir",  32'(pc_redirect),  32'd0);
        check("rst_flush",  32'(flush),        32'd0);
        check("rst_ack",    32'(irq_ack),      32'd0);
        check("rst_cause",  32'(trap_cause),   32'd0);
        check("rst_target", pc_target,         32'd0);
        rst_n = 1'b1;
        tick(2);

        // single source, retire five cycles later
        csr_mie = 1'b1; irq = 4'b0100;
        tick(5);
        retire_pulse(1'b0);
        tick(3);
        irq = '0; csr_mie = 1'b0;
        tick(3);

        // two simultaneous sources: lower index first, then the other
        csr_mie = 1'b1; irq = 4'b1010;
        tick(5);
        retire_pulse(1'b0);
        csr_mie = 1'b0;
        tick(3);
        csr_mie = 1'b1;
        tick(3);
        retire_pulse(1'b0);
        csr_mie = 1'b0; irq = '0;
        tick(3);

        // mret from idle redirects to mepc
        retire_pulse(1'b1);
        tick(3);

        // mie dropped while armed: no take, pending kept for later
        csr_mie = 1'b1; irq = 4'b0001;
        tick(5);
        csr_mie = 1'b0;
        tick(4);
        csr_mie = 1'b1;
        tick(2);
        retire_pulse(1'b0);
        csr_mie = 1'b0; irq = '0;
        tick(3);

        // mret retiring in ARMED: interrupt wins, no mepc redirect
        csr_mie = 1'b1; irq = 4'b1000;
        tick(5);
        retire_pulse(1'b1);
        csr_mie = 1'b0; irq = '0;
        tick(4);

        // reset while in TAKE, with the source still high across release
        csr_mie = 1'b1; irq = 4'b0010;
        tick(5);
        instr_retire = 1'b1;
        tick();
        instr_retire = 1'b0;
        check("take_before_rst", 32'(intrpt_taken), 32'd1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("rst_mid_taken",  32'(intrpt_taken), 32'd0);
        check("rst_mid_redir",  32'(pc_redirect),  32'd0);
        check("rst_mid_flush",  32'(flush),        32'd0);
        check("rst_mid_ack",    32'(irq_ack),      32'd0);
        check("rst_mid_cause",  32'(trap_cause),   32'd0);
        check("rst_mid_target", pc_target,         32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(6);
        retire_pulse(1'b0);
        tick(3);
        irq = '0; csr_mie = 1'b0;
        tick(3);

        // randomized traffic
        csr_mtvec = $urandom() & 32'hFFFF_FFFC;
        csr_mepc  = $urandom() & 32'hFFFF_FFFC;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < NUM_SRC; b++)
                if ($urandom_range(11, 0) == 0) irq[b] = ~irq[b];
            instr_retire = ($urandom_range(4, 0) == 0);
            mret = instr_retire && !csr_mie && ($urandom_range(2, 0) == 0);
            if (!instr_retire && $urandom_range(14, 0) == 0) csr_mie = ~csr_mie;
            if (c == 1500) begin
                rst_n = 1'b0;
                exp_q.delete();
                tick(2);
                rst_n = 1'b1;
            end
            tick();
        end
        instr_retire = 1'b0; mret = 1'b0; csr_mie = 1'b0;
        tick(5);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_otter_intrpt_ctrl
`default_nettype wire
